// File: rtl/mux_pkg.sv
// Shared constants for the arbitrating multiplexer family.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned DefaultDataPathSize = 8;

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick_n
  import mux_pkg::*;
#(
  parameter int unsigned Channels = 4,
  parameter int unsigned SelWidth = $clog2(Channels)
) (
  input  logic [Channels-1:0] req,
  input  logic [SelWidth-1:0] ptr,
  output logic [Channels-1:0] gnt,
  output logic [SelWidth-1:0] idx,
  output logic                found
);

  logic [2*Channels-1:0] req_dbl;
  logic [2*Channels-1:0] gnt_dbl;
  logic [Channels-1:0]   req_rot;
  logic [Channels-1:0]   gnt_rot;
  logic [SelWidth:0]     off;
  logic [SelWidth:0]     sum;

  always_comb begin
    // Rotate so ptr lands at bit 0, priority-encode lowest, rotate back.
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[Channels-1:0];
    found   = 1'b0;
    off     = '0;
    gnt_rot = '0;
    for (int i = Channels - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found      = 1'b1;
        off        = (SelWidth + 1)'(i);
        gnt_rot    = '0;
        gnt_rot[i] = 1'b1;
      end
    end
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    gnt     = gnt_dbl[2*Channels-1:Channels];
    sum     = off + {1'b0, ptr};
    if (sum >= (SelWidth + 1)'(Channels)) begin
      sum = sum - (SelWidth + 1)'(Channels);
    end
    idx = sum[SelWidth-1:0];
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel arbitrating mux with registered output and valid/ready handshake.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int unsigned DataPathSize = DefaultDataPathSize,
  parameter int unsigned Channels     = 4,
  parameter int unsigned SelWidth     = $clog2(Channels)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [Channels*DataPathSize-1:0] CHOICE,
  input  logic [Channels-1:0]              REQ,
  output logic [Channels-1:0]              GNT,
  input  logic                             MODE,
  input  logic [SelWidth-1:0]              SEL,
  output logic [DataPathSize-1:0]          OUT,
  output logic [SelWidth-1:0]              OUT_CH,
  output logic                             OUT_VALID,
  input  logic                             OUT_READY
);

  logic [DataPathSize-1:0] out_q, out_d;
  logic [SelWidth-1:0]     out_ch_q, out_ch_d;
  logic                    out_valid_q, out_valid_d;
  logic [SelWidth-1:0]     ptr_q, ptr_d;

  logic                    load_ok;
  logic [Channels-1:0]     pick_gnt;
  logic [SelWidth-1:0]     pick_idx;
  logic                    pick_found;
  logic [Channels-1:0]     fix_gnt;
  logic [Channels-1:0]     gnt;

  rr_pick_n #(
    .Channels (Channels),
    .SelWidth (SelWidth)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign load_ok = !out_valid_q || OUT_READY;

  always_comb begin
    fix_gnt = '0;
    if ({1'b0, SEL} < (SelWidth + 1)'(Channels)) begin
      if (REQ[SEL]) begin
        fix_gnt[SEL] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (load_ok && !RST) begin
      gnt = (MODE == MODE_RR) ? (pick_found ? pick_gnt : '0) : fix_gnt;
    end
  end

  assign GNT = gnt;

  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (|gnt) begin
      for (int k = 0; k < Channels; k++) begin
        if (gnt[k]) begin
          out_d    = CHOICE[k*DataPathSize +: DataPathSize];
          out_ch_d = SelWidth'(k);
        end
      end
      out_valid_d = 1'b1;
      if (MODE == MODE_RR) begin
        ptr_d = (pick_idx == SelWidth'(Channels - 1)) ? '0 : pick_idx + 1'b1;
      end
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_CH    = out_ch_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n with Channels = 4, DataPathSize = 8.
module tb_mux_rr_n;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] CHOICE;
  logic [3:0]  REQ;
  logic [3:0]  GNT;
  logic        MODE;
  logic [1:0]  SEL;
  logic [7:0]  OUT;
  logic [1:0]  OUT_CH;
  logic        OUT_VALID;
  logic        OUT_READY;

  int checks = 0;
  int errors = 0;

  mux_rr_n #(
    .DataPathSize (8),
    .Channels     (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CHOICE    (CHOICE),
    .REQ       (REQ),
    .GNT       (GNT),
    .MODE      (MODE),
    .SEL       (SEL),
    .OUT       (OUT),
    .OUT_CH    (OUT_CH),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; MODE = 1'b1; SEL = 2'd0; REQ = 4'b1111; OUT_READY = 1'b1;
    CHOICE = {8'h13, 8'h12, 8'h11, 8'h10};
    #2;
    checks++;
    if (GNT !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", GNT); end
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== 11'd0) begin
      errors++; $display("FAIL rst_regs got v=%b out=%h ch=%0d exp 0/00/0", OUT_VALID, OUT, OUT_CH);
    end
    step();
    RST = 1'b0;
    #1;
    checks++;
    if (GNT !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt got %b exp 0001", GNT); end
    step();
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h10, 2'd0}) begin
      errors++; $display("FAIL rst_first_word got v=%b out=%h ch=%0d exp 1/10/0", OUT_VALID, OUT, OUT_CH);
    end
    #1;
    step();
    checks++;
    if ({OUT_VALID, OUT_CH} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL rst_second_word got v=%b ch=%0d exp 1/1", OUT_VALID, OUT_CH);
    end
    // Mid-transfer asynchronous reset
    RST = 1'b1;
    #1;
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== 11'd0) begin
      errors++; $display("FAIL rst_async got v=%b out=%h ch=%0d exp 0/00/0", OUT_VALID, OUT, OUT_CH);
    end
    checks++;
    if (GNT !== 4'b0000) begin errors++; $display("FAIL rst_async_gnt got %b exp 0000", GNT); end
    RST = 1'b0;
    #1;
    checks++;
    if (GNT !== 4'b0001) begin errors++; $display("FAIL rst_release_gnt got %b exp 0001", GNT); end
    step();
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h10, 2'd0}) begin
      errors++; $display("FAIL rst_release_word got v=%b out=%h ch=%0d exp 1/10/0", OUT_VALID, OUT, OUT_CH);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    MODE = 1'b0; SEL = 2'd2; REQ = 4'b1111; OUT_READY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (GNT !== 4'b0100) begin errors++; $display("FAIL fixed_gnt cyc%0d got %b exp 0100", c, GNT); end
      step();
      checks++;
      if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h12, 2'd2}) begin
        errors++; $display("FAIL fixed_word cyc%0d got v=%b out=%h ch=%0d exp 1/12/2", c, OUT_VALID, OUT, OUT_CH);
      end
    end
    // Pointer must still be 0 after fixed-mode transfers
    MODE = 1'b1;
    #1;
    checks++;
    if (GNT !== 4'b0001) begin errors++; $display("FAIL fixed_ptr_kept got %b exp 0001", GNT); end
    step();
  endtask

  task automatic test_rr_wrap();
    logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    MODE = 1'b1; REQ = 4'b1111; OUT_READY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (GNT !== (4'b0001 << exp_ch[c])) begin
        errors++; $display("FAIL rr_gnt cyc%0d got %b exp %b", c, GNT, 4'b0001 << exp_ch[c]);
      end
      step();
      checks++;
      if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h10 + 8'(exp_ch[c]), exp_ch[c]}) begin
        errors++; $display("FAIL rr_word cyc%0d got v=%b out=%h ch=%0d exp 1/%h/%0d",
                          c, OUT_VALID, OUT, OUT_CH, 8'h10 + 8'(exp_ch[c]), exp_ch[c]);
      end
    end
  endtask

  task automatic test_sparse();
    logic [3:0] req_v [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0001};
    logic [1:0] exp_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd0};
    do_reset();
    MODE = 1'b1; OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      REQ = req_v[c];
      #1;
      checks++;
      if (GNT !== (4'b0001 << exp_ch[c])) begin
        errors++; $display("FAIL sparse_gnt step%0d got %b exp %b", c, GNT, 4'b0001 << exp_ch[c]);
      end
      step();
      checks++;
      if ({OUT_VALID, OUT_CH} !== {1'b1, exp_ch[c]}) begin
        errors++; $display("FAIL sparse_word step%0d got v=%b ch=%0d exp 1/%0d", c, OUT_VALID, OUT_CH, exp_ch[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    // Holds ch0 word 8'h10 from the sparse test
    OUT_READY = 1'b0; REQ = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (GNT !== 4'b0000) begin errors++; $display("FAIL stall_gnt cyc%0d got %b exp 0000", c, GNT); end
      step();
      checks++;
      if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h10, 2'd0}) begin
        errors++; $display("FAIL stall_hold cyc%0d got v=%b out=%h ch=%0d exp 1/10/0", c, OUT_VALID, OUT, OUT_CH);
      end
    end
    OUT_READY = 1'b1; REQ = 4'b1000;
    #1;
    checks++;
    if (GNT !== 4'b1000) begin errors++; $display("FAIL release_gnt got %b exp 1000", GNT); end
    step();
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h13, 2'd3}) begin
      errors++; $display("FAIL release_word got v=%b out=%h ch=%0d exp 1/13/3", OUT_VALID, OUT, OUT_CH);
    end
  endtask

  task automatic test_idle();
    MODE = 1'b0; SEL = 2'd3; REQ = 4'b0111; OUT_READY = 1'b1;
    CHOICE[31:24] = 8'h33;
    #1;
    checks++;
    if (GNT !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b exp 0000", GNT); end
    step();
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== {1'b0, 8'h13, 2'd3}) begin
      errors++; $display("FAIL idle_drain got v=%b out=%h ch=%0d exp 0/13/3", OUT_VALID, OUT, OUT_CH);
    end
    step();
    checks++;
    if ({OUT_VALID, OUT} !== {1'b0, 8'h13}) begin
      errors++; $display("FAIL idle_hold got v=%b out=%h exp 0/13", OUT_VALID, OUT);
    end
    REQ = 4'b1000;
    #1;
    checks++;
    if (GNT !== 4'b1000) begin errors++; $display("FAIL sel3_gnt got %b exp 1000", GNT); end
    step();
    checks++;
    if ({OUT_VALID, OUT, OUT_CH} !== {1'b1, 8'h33, 2'd3}) begin
      errors++; $display("FAIL sel3_word got v=%b out=%h ch=%0d exp 1/33/3", OUT_VALID, OUT, OUT_CH);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_wrap();
    test_sparse();
    test_backpressure();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel arbitrating multiplexer with a registered output and valid/ready handshake. It is the next generation of the datapath 4:1 selector. Channel count and width are now parameters. A mode input chooses between an externally selected channel and round-robin arbitration across requesting channels. It sits between multiple datapath producers (register-file ports, ALU, immediate path) and a single consumer stage.

## Interface

Parameters:
- `DataPathSize`, default 8: width of each channel and of `OUT`.
- `Channels`, default 4: number of input channels; must be ≥ 2.
- `SelWidth`, default `$clog2(Channels)`: width of `SEL` and `OUT_CH`. Derived; do not override.

Ports:
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `CHOICE` input `Channels*DataPathSize`: flattened channel data; channel k is `CHOICE[k*DataPathSize +: DataPathSize]`.
- `REQ` input `Channels`: per-channel valid.
- `GNT` output `Channels`: per-channel ready, combinational, one-hot or zero.
- `MODE` input 1: 0 = fixed (channel `SEL`); 1 = round-robin.
- `SEL` input `SelWidth`: channel index used in fixed mode.
- `OUT` output `DataPathSize`: registered data.
- `OUT_CH` output `SelWidth`: registered index of the source channel of `OUT`.
- `OUT_VALID` output 1: registered; `OUT`/`OUT_CH` hold a word.
- `OUT_READY` input 1: consumer accepts the word when high with `OUT_VALID`.

## Operation

- Output register state: `OUT`, `OUT_CH`, `OUT_VALID`, plus round-robin pointer `PTR` (`SelWidth` bits).
- `load_ok = !OUT_VALID || OUT_READY`. The output register is empty or being drained this cycle.
- Grant selection, combinational; `GNT` is forced to zero when `!load_ok`:
  - Fixed mode: grant channel `SEL` iff `REQ[SEL]` and `SEL < Channels`. An out-of-range `SEL` yields no grant.
  - Round-robin mode: grant the first channel with `REQ` set, scanning `PTR`, `PTR+1`, …, wrapping modulo `Channels`.
- Transfer from channel k occurs when `GNT[k]`, which implies `REQ[k]`. On the next edge:
  - `OUT` ← channel k data.
  - `OUT_CH` ← k.
  - `OUT_VALID` ← 1.
- In round-robin mode, a transfer from k sets `PTR` ← (k+1) mod `Channels`. This wraps to 0 when k = `Channels`-1.
- In fixed mode `PTR` is unchanged.
- Drain with no new grant (`OUT_VALID && OUT_READY`, no `GNT`): `OUT_VALID` ← 0. `OUT` and `OUT_CH` hold their last values.
- Drain and grant in the same cycle: the new word replaces the old one. `OUT_VALID` stays 1, with no bubble.
- Stall (`OUT_VALID && !OUT_READY`): all registers hold, `GNT` = 0, and `REQ` is ignored.
- `MODE` and `SEL` are sampled combinationally every cycle. Changing them mid-stream affects only the next grant. `PTR` is not reset on a mode change.
- Producers must hold data stable while `REQ` is high and `GNT` is low. The block imposes no ordering beyond the arbitration rule.

## Timing

- Reset values: `OUT` = 0, `OUT_CH` = 0, `OUT_VALID` = 0, `PTR` = 0. `GNT` is 0 while `RST` is high.
- Reset takes effect immediately, asynchronously. A word in flight is discarded.
- Latency: 1 cycle from the `REQ`&`GNT` edge to `OUT_VALID`.
- Throughput: 1 word/cycle when `OUT_READY` is held high.
- Round-robin fairness: with all `REQ` high and `OUT_READY` high, grants cycle 0,1,…,`Channels`-1,0,…
- `GNT` depends combinationally on `REQ`, `MODE`, `SEL`, `OUT_READY` and registered state. It must not feed back into `REQ` within the same cycle.

## Structure

- Shared package `mux_pkg`:
  - mode constants `MODE_FIXED` = 1'b0 and `MODE_RR` = 1'b1;
  - default `DataPathSize`.
- Sub-module `rr_pick_n` (parameter `Channels`): combinational priority picker.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, index, found flag.
  - Implementation: rotate–priority-encode–rotate-back.
- The top level holds the output register, `PTR`, mode muxing and handshake logic.

## Test plan

All scenarios use `Channels` = 4 and `DataPathSize` = 8.

1. Reset: assert `RST` mid-transfer with `OUT_VALID` = 1 → `OUT_VALID` = 0, `OUT` = 0, `OUT_CH` = 0 immediately; after release, first round-robin grant with `REQ` = 4'b1111 goes to channel 0.
2. Fixed mode: `MODE` = 0, `SEL` = 2, `REQ` = 4'b1111, channels = 8'h10/8'h11/8'h12/8'h13, `OUT_READY` = 1 → `GNT` = 4'b0100 every cycle; `OUT` = 8'h12, `OUT_CH` = 2 from the next cycle; `PTR` stays 0.
3. Round-robin wrap: `MODE` = 1, `REQ` = 4'b1111, `OUT_READY` = 1 for 6 cycles → `OUT_CH` sequence 0,1,2,3,0,1.
4. Sparse requests: `MODE` = 1, `PTR` = 0, `REQ` = 4'b1010 → grants 1, 3, 1; `REQ` = 4'b0001 with `PTR` = 2 → grant 0.
5. Backpressure: word loaded with `OUT_READY` = 0 for 3 cycles → `GNT` = 0, `OUT` stable. `OUT_READY` then rises with `REQ[3]` set → same cycle `GNT` = 4'b1000, next cycle `OUT` = channel 3 data, `OUT_VALID` = 1 with no bubble.
6. Out-of-range and idle cases:
   - `MODE` = 0, `SEL` = 3, `REQ[3]` = 0 → no grant; after drain, `OUT_VALID` = 0 and `OUT` holds its last value.
   - `SEL` = 3 with `REQ[3]` = 1 → granted.
